// File: rtl/cache_controller.sv
// Direct-mapped, write-back / write-allocate cache sequencer: one word per line,
// hit/miss decision, dirty-victim write-back and refill over a req/ack memory port.
module cache_controller #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_mode,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                mode_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                retry_r;
  logic [LINES-1:0]    valid_r;
  logic [LINES-1:0]    dirty_r;
  logic [TAG_W-1:0]    tag_mem_r  [LINES];
  logic [DATA_W-1:0]   data_mem_r [LINES];

  logic [INDEX_W-1:0]  index_s;
  logic [TAG_W-1:0]    tag_s;
  logic [TAG_W-1:0]    victim_tag_s;
  logic [DATA_W-1:0]   victim_data_s;
  logic                hit_s;
  logic                load_s;
  logic                ready_s;
  logic                rd_hit_s;
  logic                wr_line_s;
  logic                wb_done_s;
  logic                refill_s;
  logic                count_hit_s;
  logic                count_miss_s;

  // Line lookup for the latched request
  always_comb begin
    index_s       = addr_r[INDEX_W-1:0];
    tag_s         = addr_r[ADDR_W-1:INDEX_W];
    victim_tag_s  = tag_mem_r[index_s];
    victim_data_s = data_mem_r[index_s];
    hit_s         = valid_r[index_s] && (victim_tag_s == tag_s);
  end

  // Next-state and per-cycle action decode
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    ready_s      = 1'b0;
    rd_hit_s     = 1'b0;
    wr_line_s    = 1'b0;
    wb_done_s    = 1'b0;
    refill_s     = 1'b0;
    count_hit_s  = 1'b0;
    count_miss_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          load_s       = 1'b1;
          next_state_s = COMPARE;
        end else begin
          next_state_s = IDLE;
        end
      end
      COMPARE: begin
        // Statistics see only the first lookup; the post-refill re-compare is not a new request.
        count_hit_s  = hit_s && !retry_r;
        count_miss_s = !hit_s && !retry_r;
        if (hit_s) begin
          ready_s      = 1'b1;
          next_state_s = IDLE;
          if (mode_r) begin
            wr_line_s = 1'b1;
          end else begin
            rd_hit_s = 1'b1;
          end
        end else if (valid_r[index_s] && dirty_r[index_s]) begin
          next_state_s = WRITEBACK;
        end else if (!mode_r) begin
          next_state_s = REFILL;
        end else begin
          wr_line_s    = 1'b1;
          ready_s      = 1'b1;
          next_state_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          wb_done_s    = 1'b1;
          next_state_s = COMPARE;
        end else begin
          next_state_s = WRITEBACK;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          refill_s     = 1'b1;
          next_state_s = COMPARE;
        end else begin
          next_state_s = REFILL;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Control state, request latches, line status, response and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      mode_r     <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      retry_r    <= 1'b0;
      valid_r    <= {LINES{1'b0}};
      dirty_r    <= {LINES{1'b0}};
      cpu_ready  <= 1'b0;
      cpu_rdata  <= {DATA_W{1'b0}};
      hit_count  <= {CNT_W{1'b0}};
      miss_count <= {CNT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      cpu_ready <= ready_s;
      if (load_s) begin
        mode_r  <= cpu_mode;
        addr_r  <= cpu_addr;
        wdata_r <= cpu_wdata;
        retry_r <= 1'b0;
      end
      if (wb_done_s || refill_s) begin
        retry_r <= 1'b1;
      end
      if (rd_hit_s) begin
        cpu_rdata <= victim_data_s;
      end
      if (wr_line_s) begin
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b1;
      end
      if (refill_s) begin
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b0;
      end
      if (wb_done_s) begin
        dirty_r[index_s] <= 1'b0;
      end
      if (count_hit_s && (hit_count != {CNT_W{1'b1}})) begin
        hit_count <= hit_count + CNT_W'(1'b1);
      end
      if (count_miss_s && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + CNT_W'(1'b1);
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents
  always_ff @(posedge clk) begin
    if (wr_line_s) begin
      data_mem_r[index_s] <= wdata_r;
      tag_mem_r[index_s]  <= tag_s;
    end else if (refill_s) begin
      data_mem_r[index_s] <= mem_rdata;
      tag_mem_r[index_s]  <= tag_s;
    end
  end

  assign mem_req   = (state_r == WRITEBACK) || (state_r == REFILL);
  assign mem_we    = (state_r == WRITEBACK);
  assign mem_addr  = (state_r == WRITEBACK) ? {victim_tag_s, index_s} : addr_r;
  assign mem_wdata = victim_data_s;

endmodule
